// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : big-endian byte-stream loader for instruction memory; holds
// the core in reset until a whole image is written. Optional LOADER_CHECKSUM_EN
// adds a trailing XOR checksum byte.  Rev 1.0
// ============================================================================
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHK    = 3'd3,
`endif
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       n;
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   idx_inc;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_sh;
  logic [15:0]       hdr_n;
  logic              accept;
  logic              last_word;
  logic              restart;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign accept    = in_valid && in_ready;
  assign hdr_n     = {n[15:8], in_data};
  assign idx_inc   = word_idx + 1'b1;
  // word_idx is one bit wider than the address so N == DEPTH terminates cleanly
  assign last_word = (32'(idx_inc) == 32'(n));
  assign restart   = ((state == S_DONE) || (state == S_ERR)) && reload;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= S_HDR_HI;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cpu_rst   = 1'b1;
    case (state)
      S_HDR_HI: begin
        in_ready = 1'b1;
        if (accept) state_nxt = S_HDR_LO;
      end
      S_HDR_LO: begin
        in_ready = 1'b1;
        if (accept) begin
          if ({16'd0, hdr_n} > DEPTH) begin
            state_nxt = S_ERR;
          end else if (hdr_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_nxt = S_CHK;
`else
            state_nxt = S_DONE;
`endif
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (accept && (byte_cnt == 2'd3) && last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = S_CHK;
`else
          state_nxt = S_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        if (accept) state_nxt = (in_data == csum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
        if (reload) state_nxt = S_HDR_HI;
      end
      S_ERR: begin
        err = 1'b1;
        if (reload) state_nxt = S_HDR_HI;
      end
      default: state_nxt = S_HDR_HI;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      n        <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      word_sh  <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (restart) begin
        word_idx <= '0;
        byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end else if (accept) begin
`ifdef LOADER_CHECKSUM_EN
        csum <= csum ^ in_data;
`endif
        case (state)
          S_HDR_HI: n[15:8] <= in_data;
          S_HDR_LO: n[7:0]  <= in_data;
          S_DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_we   <= 1'b1;
              mem_addr <= word_idx[ADDR_W-1:0];
              mem_data <= {word_sh, in_data};
              word_idx <= idx_inc;
            end else begin
              word_sh <= {word_sh[15:0], in_data};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that writes instruction memory and holds the KGP_RISC core in reset until a complete image is in place. The core only reads instruction memory; this block is its writer. It accepts bytes over a valid/ready handshake, packs them big-endian into 32-bit words, writes them to consecutive addresses, then releases the core.

## Interface

- ADDR_W, 10, instruction memory address width; DEPTH = 2^ADDR_W words
- DATA_W, 32, instruction word width; fixed at 4 bytes per word

- clock  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  loader can accept a byte this cycle
- reload  in  1  one-cycle pulse: restart loading (honoured only in DONE/ERR)
- mem_we  out  1  instruction memory write enable, one cycle per word
- mem_addr  out  ADDR_W  write address
- mem_data  out  DATA_W  write data
- cpu_rst  out  1  reset to core; high until a good image is loaded
- done  out  1  image loaded and core released
- err  out  1  load failed; core held in reset

## Operation

- A byte is accepted on a rising edge where in_valid && in_ready. Unaccepted bytes are ignored, and in_data must hold until accepted.
- Frame: header of 2 bytes (word count N, high byte first), then 4·N payload bytes, then one checksum byte when LOADER_CHECKSUM_EN is defined.
- States:
  - HDR_HI: latch N[15:8], go to HDR_LO.
  - HDR_LO: latch N[7:0].
    - N > DEPTH: go to ERR.
    - N == 0: go to CHK if enabled, else DONE.
    - Otherwise: go to DATA.
  - DATA: shift the byte into the word register, first byte into bits [31:24]. On the 4th byte:
    - Write the word at address word_idx.
    - Increment word_idx.
    - After word N, go to CHK if enabled, else DONE.
  - CHK: compare the byte with the running checksum. Match goes to DONE; mismatch goes to ERR.
  - DONE: done=1, cpu_rst=0, in_ready=0.
  - ERR: err=1, cpu_rst=1, in_ready=0.
- reload in DONE or ERR:
  - Go to HDR_HI.
  - Clear word_idx, byte counter, checksum, done and err.
  - Assert cpu_rst the next cycle.
- reload in any other state is ignored.
- in_ready = 1 in HDR_HI, HDR_LO, DATA and CHK.
- Memory words beyond N are not written; old contents remain.
- Address arithmetic: word_idx is ADDR_W+1 bits wide so that N == DEPTH is legal. mem_addr = word_idx[ADDR_W-1:0], and it never wraps within a frame.

## Timing

- Reset values:
  - State: HDR_HI.
  - in_ready=1.
  - mem_we=0, mem_addr=0, mem_data=0.
  - cpu_rst=1.
  - done=0, err=0.
- Write latency: if the 4th byte of a word is accepted at edge t, mem_we=1 with valid mem_addr/mem_data during cycle t+1 (registered). mem_we is low otherwise.
- Back-to-back bytes are accepted every cycle with no stalls. Throughput is one word per 4 cycles.
- Release timing:
  - Final byte (last payload byte, or checksum byte) accepted at edge t: done=1 and cpu_rst=0 from cycle t+1.
  - Without checksum, the last mem_we is in the same cycle that done rises.
- Error timing: err=1 from the cycle after the offending byte is accepted.
- reload sampled at edge t: cpu_rst=1, done=0, err=0 and in_ready=1 from cycle t+1.
- Async rst mid-frame: returns immediately to reset values; partial words are discarded. Memory already written is not rolled back.

## Configuration

- LOADER_CHECKSUM_EN defined:
  - Running XOR of all header and payload bytes.
  - Checksum byte required after the payload; CHK state present.
  - Mismatch leads to ERR.
- LOADER_CHECKSUM_EN undefined:
  - No CHK state and no checksum register.
  - After word N (or header N=0) the loader goes straight to DONE.
  - err is asserted only for N > DEPTH.

## Test plan

- Reset, then stream 00 02 12 34 56 78 9A BC DE F0 every cycle, no checksum:
  - mem_we pulses twice: addr0=0x12345678, addr1=0x9ABCDEF0.
  - done=1 and cpu_rst=0 the cycle after byte F0.
- Same frame with LOADER_CHECKSUM_EN and trailing byte 0x02 (XOR of all 10 bytes): DONE.
- Repeat with trailing byte 0x03: err=1 and cpu_rst stays 1.
- Header 0x04 0x01 with ADDR_W=10 (N=1025 > 1024): ERR after the second byte, no mem_we.
- in_valid toggled randomly during a 3-word frame: identical writes in order, in_data held while not accepted, no duplicate or lost bytes.
- Assert rst after 6 bytes of a 2-word frame:
  - cpu_rst=1 and done=0 immediately.
  - A fresh frame 00 01 AA BB CC DD then writes addr0=0xAABBCCDD.
- In DONE, pulse reload and send 00 00 (no checksum):
  - cpu_rst pulses high, no mem_we.
  - done returns the cycle after the second 00.
